// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster timing constants and shared helpers
package vga_pkg;

    localparam int COORD_W = 16;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Half-open window test [lo, hi) on a coordinate.
    function automatic logic in_window(input logic [COORD_W-1:0] val,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// rtl/vga_timing_gen_delay_line.sv - enabled shift register with async reset value
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, rst_n, en, rst_val};
            assign dout = din;
        end else begin : g_stages
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= rst_val;
                    end
                end else if (en) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, sync/strobe generation and registered VGA pin stage
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    input  logic [7:0]         r_in,
    input  logic [7:0]         g_in,
    input  logic [7:0]         b_in,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SS       = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SE       = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SS       = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SE       = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    logic hs_raw;
    logic vs_raw;

    // vs only looks at v_cnt, so it can only move when h_cnt wraps to 0.
    assign hs_raw = in_window(h_cnt, H_SS, H_SE) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = in_window(v_cnt, V_SS, V_SE) ? SYNC_POL : ~SYNC_POL;

    assign x      = h_cnt;
    assign y      = v_cnt;
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Gated by rst_n so the strobes read low while reset is held.
    assign line_start  = en && rst_n && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    logic [2:0] dly_out;

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_delay_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .rst_val ({~SYNC_POL, ~SYNC_POL, 1'b0}),
        .din     ({hs_raw, vs_raw, active}),
        .dout    (dly_out)
    );

    logic d_hs;
    logic d_vs;
    logic d_act;

    assign {d_hs, d_vs, d_act} = dly_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_de <= 1'b0;
            vga_r  <= 8'd0;
            vga_g  <= 8'd0;
            vga_b  <= 8'd0;
        end else if (en) begin
            vga_hs <= d_hs;
            vga_vs <= d_vs;
            vga_de <= d_act;
            vga_r  <= d_act ? r_in : 8'd0;
            vga_g  <= d_act ? g_in : 8'd0;
            vga_b  <= d_act ? b_in : 8'd0;
        end
    end

endmodule
